// File: rtl/coproc_pkg.sv
// coproc_pkg: shared constants for the matrix-coprocessor command issuer.
// Holds the opcode map, the instruction field layout and the issuer FSM encoding.
package coproc_pkg;

  // Instruction field layout: [3:0] opcode, [11:4] addr, [27:12] data, [31:28] zero
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int ADDR_LSB = 4;
  localparam int ADDR_W   = 8;
  localparam int DATA_LSB = 12;
  localparam int DATA_W   = 16;
  localparam int CMD_W    = OP_W + ADDR_W + DATA_W;
  localparam int INSTR_W  = 32;

  // Coprocessor opcodes; 0 and 13..15 are illegal
  localparam logic [OP_W-1:0] OP_READ   = 4'd1;
  localparam logic [OP_W-1:0] OP_WRITE  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUM    = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB    = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL    = 4'd5;
  localparam logic [OP_W-1:0] OP_TRANSP = 4'd6;
  localparam logic [OP_W-1:0] OP_OPST   = 4'd7;
  localparam logic [OP_W-1:0] OP_MULSCL = 4'd8;
  localparam logic [OP_W-1:0] OP_DET2   = 4'd9;
  localparam logic [OP_W-1:0] OP_DET3   = 4'd10;
  localparam logic [OP_W-1:0] OP_DET4   = 4'd11;
  localparam logic [OP_W-1:0] OP_DET5   = 4'd12;

  // Issuer FSM encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } issuer_state_e;

  // True for opcodes the coprocessor understands
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op >= OP_READ) && (op <= OP_DET5);
  endfunction

  // FIFO entry layout is identical to instruction bits [27:0]
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [OP_W-1:0]   op,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data);
    return {data, addr, op};
  endfunction

endpackage

// File: rtl/coproc_issuer_cmd_fifo.sv
// issuer_cmd_fifo: synchronous command FIFO with registered full/empty flags.
// Pointers wrap naturally because DEPTH is a power of two.
module issuer_cmd_fifo
  import coproc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             empty_next
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok_s, pop_ok_s;

  assign push_ok_s  = push & ~full_q;
  assign pop_ok_s   = pop & ~empty_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign full       = full_q;
  assign empty      = empty_q;
  assign empty_next = empty_d;

  // Next pointers, occupancy and flags from this cycle's push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == {CW{1'b0}});
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/coproc_issuer.sv
// coproc_issuer: buffers host commands, packs them into coprocessor instructions,
// strobes activate_instruction and returns one in-order response per command.
// Optional macro ISSUER_TIMEOUT_EN: bound the WAIT state to TIMEOUT_CYCLES and
// answer with an error response (data 16'hFFFF) when the coprocessor stays silent.
module coproc_issuer
  import coproc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_opcode,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               activate_instruction,
  input  logic               cop_done,
  input  logic [DATA_W-1:0]  cop_result,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  // One counter serves both the activate pulse and the WAIT timeout
  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  issuer_state_e      state_q, state_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               activate_q, activate_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               last_done_q;

  logic               fifo_push_s, fifo_pop_s;
  logic               fifo_full_s, fifo_empty_s, fifo_empty_next_s;
  logic [CMD_W-1:0]   fifo_head_s;
  logic [OP_W-1:0]    head_op_s;
  logic               done_rise_s;

  assign cmd_ready   = ~fifo_full_s;
  assign fifo_push_s = cmd_valid & ~fifo_full_s;
  assign head_op_s   = fifo_head_s[OP_LSB +: OP_W];
  assign done_rise_s = cop_done & ~last_done_q;

  issuer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push_s),
    .wr_data    (pack_cmd(cmd_opcode, cmd_addr, cmd_data)),
    .pop        (fifo_pop_s),
    .rd_data    (fifo_head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .empty_next (fifo_empty_next_s)
  );

  // Next-state and next-output computation for the issue FSM
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    activate_d    = activate_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    fifo_pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          if (is_legal_op(head_op_s)) begin
            instruction_d = {4'h0, fifo_head_s};
            op_d          = head_op_s;
            state_d       = S_LOAD;
          end else begin
            // Illegal opcode: nothing is issued, answer with an error
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        activate_d = 1'b1;
        cnt_d      = {CNT_W{1'b0}};
        state_d    = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          activate_d = 1'b0;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (done_rise_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = (op_q == OP_WRITE) ? 16'h0000 : cop_result;
          state_d     = S_RESP;
        end
`ifdef ISSUER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 16'hFFFF;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        activate_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) || !fifo_empty_next_s;
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instruction_q <= {INSTR_W{1'b0}};
      activate_q    <= 1'b0;
      op_q          <= {OP_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      last_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      activate_q    <= activate_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      last_done_q   <= cop_done;
    end
  end

  assign instruction          = instruction_q;
  assign activate_instruction = activate_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = rsp_data_q;
  assign rsp_err              = rsp_err_q;
  assign busy                 = busy_q;

endmodule
